// File: rtl/program_loader.sv
// program_loader: writer side of the core's instruction/data RAM.
// Takes 32-bit words from a valid/ready stream, writes them as four
// little-endian bytes at consecutive addresses and holds the core in reset
// until the whole image has been written.
// Optional: define LOADER_CHECKSUM_EN for a modulo-256 sum of written bytes.
module program_loader #(
    parameter int unsigned RAMSIZE = 64,
    parameter int unsigned ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_word,
    input  logic              in_last,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W-1:0] byte_count,
    output logic              core_reset,
    output logic [7:0]        checksum
);

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        WRITE,
        DONE,
        ERROR
    } stateType;

    stateType          state, stateNext;
    logic [ADDR_W-1:0] addr, addrNext;
    logic [31:0]       word, wordNext;
    logic              last, lastNext;
    logic [1:0]        lane, laneNext;

    logic              inReadyNext;
    logic              ramWeNext;
    logic [ADDR_W-1:0] ramAddrNext;
    logic [7:0]        ramWdataNext;
    logic              busyNext;
    logic              doneNext;
    logic              overflowNext;
    logic [ADDR_W-1:0] byteCountNext;
    logic              coreResetNext;
    logic [7:0]        laneByte;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum, sumNext;
    assign checksum = sum;
`else
    assign checksum = 8'h00;
`endif

    // Byte of the latched word selected by the current lane (byte0 first).
    assign laneByte = 8'(word >> {lane, 3'b000});

    // State and registered-output update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr       <= '0;
            word       <= '0;
            last       <= 1'b0;
            lane       <= 2'd0;
            in_ready   <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            byte_count <= '0;
            core_reset <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum        <= 8'h00;
`endif
        end else begin
            state      <= stateNext;
            addr       <= addrNext;
            word       <= wordNext;
            last       <= lastNext;
            lane       <= laneNext;
            in_ready   <= inReadyNext;
            ram_we     <= ramWeNext;
            ram_addr   <= ramAddrNext;
            ram_wdata  <= ramWdataNext;
            busy       <= busyNext;
            done       <= doneNext;
            overflow   <= overflowNext;
            byte_count <= byteCountNext;
            core_reset <= coreResetNext;
`ifdef LOADER_CHECKSUM_EN
            sum        <= sumNext;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        stateNext     = state;
        addrNext      = addr;
        wordNext      = word;
        lastNext      = last;
        laneNext      = lane;
        ramWeNext     = 1'b0;
        ramAddrNext   = ram_addr;
        ramWdataNext  = ram_wdata;
        doneNext      = done;
        overflowNext  = overflow;
        byteCountNext = byte_count;
`ifdef LOADER_CHECKSUM_EN
        sumNext       = sum;
`endif

        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    addrNext      = start_addr;
                    doneNext      = 1'b0;
                    overflowNext  = 1'b0;
                    byteCountNext = '0;
`ifdef LOADER_CHECKSUM_EN
                    sumNext       = 8'h00;
`endif
                    stateNext     = ACCEPT;
                end
            end
            ACCEPT: begin
                if (in_valid && in_ready) begin
                    wordNext  = in_word;
                    lastNext  = in_last;
                    laneNext  = 2'd0;
                    stateNext = WRITE;
                end
            end
            WRITE: begin
                // Bound check precedes every byte; bytes already written stay.
                if (32'(addr) >= RAMSIZE) begin
                    overflowNext = 1'b1;
                    stateNext    = ERROR;
                end else begin
                    ramWeNext     = 1'b1;
                    ramAddrNext   = addr;
                    ramWdataNext  = laneByte;
                    addrNext      = addr + ADDR_W'(1);
                    byteCountNext = byte_count + ADDR_W'(1);
`ifdef LOADER_CHECKSUM_EN
                    sumNext       = sum + laneByte;
`endif
                    laneNext      = lane + 2'd1;
                    if (lane == 2'd3) begin
                        stateNext = last ? DONE : ACCEPT;
                        doneNext  = last;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase

        inReadyNext   = (stateNext == ACCEPT);
        busyNext      = (stateNext == ACCEPT) || (stateNext == WRITE);
        coreResetNext = (stateNext != DONE);
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: randomized sessions checked
// against a byte-level RAM write model built from the word list.
module tb_program_loader;

    localparam int RAMSIZE = 64;
    localparam int ADDR_W  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_word;
    logic              in_last;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [ADDR_W-1:0] byte_count;
    logic              core_reset;
    logic [7:0]        checksum;

    int compared   = 0;
    int mismatched = 0;

    int          obsAddr[$];
    int          obsData[$];
    int          expAddr[$];
    int          expData[$];
    bit          expOvf;
    int          expSum;
    logic [31:0] sessWords[$];

    program_loader #(.RAMSIZE(RAMSIZE), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .in_last(in_last), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .busy(busy), .done(done), .overflow(overflow),
        .byte_count(byte_count), .core_reset(core_reset), .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Record every RAM write seen on the bus.
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            obsAddr.push_back(int'(ram_addr));
            obsData.push_back(int'(ram_wdata));
        end
    end

    // Expected byte writes for a session starting at a with sessWords.
    task automatic buildModel(input int a);
        expAddr.delete();
        expData.delete();
        expOvf = 0;
        expSum = 0;
        foreach (sessWords[w]) begin
            for (int b = 0; b < 4; b++) begin
                int ad;
                int dat;
                ad = a + 4 * w + b;
                if (ad >= RAMSIZE) begin
                    expOvf = 1;
                    break;
                end
                dat = int'((sessWords[w] >> (8 * b)) & 32'hFF);
                expAddr.push_back(ad);
                expData.push_back(dat);
                expSum = (expSum + dat) % 256;
            end
            if (expOvf) break;
        end
`ifndef LOADER_CHECKSUM_EN
        expSum = 0;
`endif
    endtask

    task automatic pulseStart(input int a);
        @(negedge clk);
        start      = 1'b1;
        start_addr = 8'(a);
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Offer one word; returns at the negedge after acceptance.
    task automatic sendWord(input logic [31:0] w, input bit l, output bit ok);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_word  = w;
        in_last  = l;
        n = 0;
        while (in_ready !== 1'b1 && overflow !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = (in_ready === 1'b1);
        if (ok) @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic waitEnd(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && overflow !== 1'b1 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (n >= 80) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: done=%b overflow=%b, required one of them high", name, done, overflow);
        end
        @(negedge clk);
    endtask

    task automatic runSession(input int a);
        bit ok;
        obsAddr.delete();
        obsData.delete();
        pulseStart(a);
        foreach (sessWords[i]) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (overflow === 1'b1) break;
            sendWord(sessWords[i], i == sessWords.size() - 1, ok);
            if (!ok) break;
        end
        waitEnd("session");
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; start_addr = '0;
        in_valid = 1'b0; in_word = '0; in_last = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if ({in_ready, ram_we, busy, done, overflow, core_reset} !== 6'b000001) begin
            mismatched++;
            $display("FAIL reset_flags: got %b required 000001", {in_ready, ram_we, busy, done, overflow, core_reset});
        end
        compared++;
        if ({ram_addr, ram_wdata, byte_count, checksum} !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_buses: got %h required 0", {ram_addr, ram_wdata, byte_count, checksum});
        end
        reset = 1'b0;
        obsAddr.delete();
        obsData.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'(i % 2);
            in_word  = $urandom;
            in_last  = 1'b1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if (obsAddr.size() != 0 || in_ready !== 1'b0 || core_reset !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_ignore: writes=%0d in_ready=%b core_reset=%b busy=%b required 0/0/1/0", obsAddr.size(), in_ready, core_reset, busy);
        end
    endtask

    task automatic test_basic;
        sessWords = '{32'h00150001, 32'h00230101};
        buildModel(0);
        runSession(0);
        compared++;
        if (obsAddr.size() != expAddr.size()) begin
            mismatched++;
            $display("FAIL basic_nwrites: got %0d required %0d", obsAddr.size(), expAddr.size());
        end
        foreach (expAddr[i]) if (i < obsAddr.size()) begin
            compared++;
            if (obsAddr[i] != expAddr[i] || obsData[i] != expData[i]) begin
                mismatched++;
                $display("FAIL basic_write%0d: got %0d:%h required %0d:%h", i, obsAddr[i], obsData[i], expAddr[i], expData[i]);
            end
        end
        compared++;
        if (byte_count !== 8'd8 || done !== 1'b1 || core_reset !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_status: count=%0d done=%b core_reset=%b busy=%b ovf=%b required 8/1/0/0/0", byte_count, done, core_reset, busy, overflow);
        end
        compared++;
        if (checksum !== 8'(expSum)) begin
            mismatched++;
            $display("FAIL basic_checksum: got %h required %h", checksum, 8'(expSum));
        end
    endtask

    task automatic test_overflow;
        sessWords = '{$urandom, $urandom};
        buildModel(60);
        runSession(60);
        compared++;
        if (obsAddr.size() != 4) begin
            mismatched++;
            $display("FAIL ovf_nwrites: got %0d required 4", obsAddr.size());
        end
        foreach (expAddr[i]) if (i < obsAddr.size()) begin
            compared++;
            if (obsAddr[i] != expAddr[i] || obsData[i] != expData[i]) begin
                mismatched++;
                $display("FAIL ovf_write%0d: got %0d:%h required %0d:%h", i, obsAddr[i], obsData[i], expAddr[i], expData[i]);
            end
        end
        repeat (4) @(negedge clk);
        compared++;
        if (overflow !== 1'b1 || done !== 1'b0 || core_reset !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || byte_count !== 8'd4 || ram_we !== 1'b0) begin
            mismatched++;
            $display("FAIL ovf_status: ovf=%b done=%b core_reset=%b in_ready=%b busy=%b count=%0d we=%b required 1/0/1/0/0/4/0", overflow, done, core_reset, in_ready, busy, byte_count, ram_we);
        end
        compared++;
        if (checksum !== 8'(expSum)) begin
            mismatched++;
            $display("FAIL ovf_checksum: got %h required %h", checksum, 8'(expSum));
        end
    endtask

    task automatic test_random;
        for (int s = 0; s < 10; s++) begin
            int a;
            int nw;
            a  = $urandom_range(0, 70);
            nw = $urandom_range(1, 5);
            sessWords.delete();
            for (int k = 0; k < nw; k++) sessWords.push_back($urandom);
            buildModel(a);
            runSession(a);
            compared++;
            if (obsAddr.size() != expAddr.size()) begin
                mismatched++;
                $display("FAIL rand%0d_nwrites: got %0d required %0d", s, obsAddr.size(), expAddr.size());
            end
            foreach (expAddr[i]) if (i < obsAddr.size()) begin
                compared++;
                if (obsAddr[i] != expAddr[i] || obsData[i] != expData[i]) begin
                    mismatched++;
                    $display("FAIL rand%0d_write%0d: got %0d:%h required %0d:%h", s, i, obsAddr[i], obsData[i], expAddr[i], expData[i]);
                end
            end
            compared++;
            if (overflow !== expOvf || done !== !expOvf || core_reset !== expOvf || byte_count !== 8'(expAddr.size()) || checksum !== 8'(expSum)) begin
                mismatched++;
                $display("FAIL rand%0d_status: ovf=%b done=%b core_reset=%b count=%0d sum=%h required ovf=%b count=%0d sum=%h", s, overflow, done, core_reset, byte_count, checksum, expOvf, expAddr.size(), 8'(expSum));
            end
        end
    endtask

    task automatic test_stall;
        bit ok;
        logic [31:0] w;
        bit stallBad;
        w = $urandom;
        sessWords = '{w};
        buildModel(20);
        obsAddr.delete();
        obsData.delete();
        pulseStart(20);
        stallBad = 0;
        repeat (10) begin
            @(negedge clk);
            if (in_ready !== 1'b1 || ram_we !== 1'b0) stallBad = 1;
        end
        compared++;
        if (stallBad) begin
            mismatched++;
            $display("FAIL stall_ready: in_ready=%b ram_we=%b required in_ready 1, no write while idle in ACCEPT", in_ready, ram_we);
        end
        sendWord(w, 1'b1, ok);
        compared++;
        if (!ok || ram_we !== 1'b0) begin
            mismatched++;
            $display("FAIL stall_accept: ok=%b ram_we=%b required 1/0", ok, ram_we);
        end
        @(negedge clk);
        compared++;
        if (ram_we !== 1'b1 || ram_addr !== 8'd20 || ram_wdata !== w[7:0]) begin
            mismatched++;
            $display("FAIL stall_first: we=%b addr=%0d data=%h required 1/20/%h", ram_we, ram_addr, ram_wdata, w[7:0]);
        end
        waitEnd("stall");
        compared++;
        if (obsAddr.size() != 4 || done !== 1'b1) begin
            mismatched++;
            $display("FAIL stall_nwrites: got %0d done=%b required 4/1", obsAddr.size(), done);
        end
        foreach (expAddr[i]) if (i < obsAddr.size()) begin
            compared++;
            if (obsAddr[i] != expAddr[i] || obsData[i] != expData[i]) begin
                mismatched++;
                $display("FAIL stall_write%0d: got %0d:%h required %0d:%h", i, obsAddr[i], obsData[i], expAddr[i], expData[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        obsAddr.delete();
        pulseStart(8);
        sendWord($urandom, 1'b0, ok);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        compared++;
        if (ram_we !== 1'b0 || core_reset !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || byte_count !== 8'd0 || ram_addr !== 8'd0 || ram_wdata !== 8'd0 || done !== 1'b0 || overflow !== 1'b0 || checksum !== 8'd0) begin
            mismatched++;
            $display("FAIL midreset_values: we=%b core_reset=%b in_ready=%b busy=%b count=%0d addr=%0d required reset values", ram_we, core_reset, in_ready, busy, byte_count, ram_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        sessWords = '{$urandom};
        buildModel(16);
        runSession(16);
        compared++;
        if (obsAddr.size() != 4 || done !== 1'b1 || byte_count !== 8'd4) begin
            mismatched++;
            $display("FAIL midreset_restart: writes=%0d done=%b count=%0d required 4/1/4", obsAddr.size(), done, byte_count);
        end
        foreach (expAddr[i]) if (i < obsAddr.size()) begin
            compared++;
            if (obsAddr[i] != expAddr[i] || obsData[i] != expData[i]) begin
                mismatched++;
                $display("FAIL midreset_write%0d: got %0d:%h required %0d:%h", i, obsAddr[i], obsData[i], expAddr[i], expData[i]);
            end
        end
    endtask

    task automatic test_start_ignore;
        bit ok;
        sessWords = '{$urandom, $urandom, $urandom};
        buildModel(4);
        obsAddr.delete();
        obsData.delete();
        pulseStart(4);
        sendWord(sessWords[0], 1'b0, ok);
        start      = 1'b1;
        start_addr = 8'd40;
        @(negedge clk);
        start      = 1'b0;
        sendWord(sessWords[1], 1'b0, ok);
        sendWord(sessWords[2], 1'b1, ok);
        waitEnd("startignore");
        compared++;
        if (obsAddr.size() != expAddr.size() || done !== 1'b1 || byte_count !== 8'd12) begin
            mismatched++;
            $display("FAIL startignore_nwrites: got %0d done=%b count=%0d required %0d/1/12", obsAddr.size(), done, byte_count, expAddr.size());
        end
        foreach (expAddr[i]) if (i < obsAddr.size()) begin
            compared++;
            if (obsAddr[i] != expAddr[i] || obsData[i] != expData[i]) begin
                mismatched++;
                $display("FAIL startignore_write%0d: got %0d:%h required %0d:%h", i, obsAddr[i], obsData[i], expAddr[i], expData[i]);
            end
        end
        pulseStart(0);
        compared++;
        if (done !== 1'b0 || core_reset !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b1 || byte_count !== 8'd0) begin
            mismatched++;
            $display("FAIL done_restart: done=%b core_reset=%b busy=%b in_ready=%b count=%0d required 0/1/1/1/0", done, core_reset, busy, in_ready, byte_count);
        end
        sendWord($urandom, 1'b1, ok);
        waitEnd("cleanup");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_random();
        test_stall();
        test_reset_mid();
        test_start_ignore();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
